// File: rtl/pipeline_sequencer.sv
// pipeline_sequencer
//   Run-control and hazard controller for the 5-stage MIPS pipeline.
//   Decides each cycle whether the pipeline advances, stalls on a load-use
//   hazard, flushes IF/ID on a taken jump/branch, or drains after HALT.
//   Supports continuous and single-step execution for a debug host.
//
// Ports
//   i_clk, i_reset        clock; synchronous active-high reset to IDLE
//   i_start, i_step_mode  leave IDLE into RUN (mode 0) or STEP_WAIT (mode 1)
//   i_step                one advance per high cycle while in STEP_WAIT
//   i_halt_id             HALT is in ID
//   i_jump_taken          jump / taken branch resolved in ID
//   i_id_rs, i_id_rt, i_id_uses_rt   source registers of the ID instruction
//   i_ex_mem_read, i_ex_rt           load in EX and its destination
//   o_adv                 enable for ID/EX, EX/MEM, MEM/WB
//   o_pc_we, o_if_id_we   PC and IF/ID write enables
//   o_if_id_flush         load NOP into IF/ID
//   o_id_ex_bubble        zero control into ID/EX
//   o_busy, o_done        RUN/STEP_WAIT/DRAIN, and DONE
//   o_state               IDLE=0 RUN=1 STEP_WAIT=2 DRAIN=3 DONE=4
//   o_cycle_cnt           saturating count of advance cycles since start
module pipeline_sequencer #(
  parameter int N_BITS_REG   = 5,
  parameter int N_BITS_CNT   = 32,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_start,
  input  logic                  i_step_mode,
  input  logic                  i_step,
  input  logic                  i_halt_id,
  input  logic                  i_jump_taken,
  input  logic [N_BITS_REG-1:0] i_id_rs,
  input  logic [N_BITS_REG-1:0] i_id_rt,
  input  logic                  i_id_uses_rt,
  input  logic                  i_ex_mem_read,
  input  logic [N_BITS_REG-1:0] i_ex_rt,
  output logic                  o_adv,
  output logic                  o_pc_we,
  output logic                  o_if_id_we,
  output logic                  o_if_id_flush,
  output logic                  o_id_ex_bubble,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [2:0]            o_state,
  output logic [N_BITS_CNT-1:0] o_cycle_cnt
);

  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RUN       = 3'd1,
    STEP_WAIT = 3'd2,
    DRAIN     = 3'd3,
    DONE      = 3'd4
  } state_t;

  state_t                state, state_nxt;
  logic [DW-1:0]         drain_cnt, drain_nxt;
  logic [N_BITS_CNT-1:0] cycle_cnt;

  logic hz;
  logic adv, pc_we, if_id_we, if_id_flush, id_ex_bubble;

  function automatic logic [N_BITS_CNT-1:0] sat_inc(input logic [N_BITS_CNT-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Load in EX whose destination is read by ID; r0 never creates a hazard.
  assign hz = i_ex_mem_read && (i_ex_rt != '0) &&
              ((i_ex_rt == i_id_rs) || (i_id_uses_rt && (i_ex_rt == i_id_rt)));

  always_comb begin
    state_nxt    = state;
    drain_nxt    = drain_cnt;
    adv          = 1'b0;
    pc_we        = 1'b0;
    if_id_we     = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;

    case (state)
      IDLE: begin
        if (i_start) state_nxt = i_step_mode ? STEP_WAIT : RUN;
      end
      RUN, STEP_WAIT: begin
        adv = (state == RUN) || i_step;
        if (adv) begin
          if (hz) begin
            id_ex_bubble = 1'b1;
          end else if (i_halt_id) begin
            // HALT moves into EX; fetch freezes and the drain begins.
            state_nxt = DRAIN;
            drain_nxt = '0;
          end else begin
            pc_we       = 1'b1;
            if_id_we    = 1'b1;
            if_id_flush = i_jump_taken;
          end
        end
      end
      DRAIN: begin
        adv          = 1'b1;
        if_id_flush  = 1'b1;
        id_ex_bubble = 1'b1;
        drain_nxt    = drain_cnt + 1'b1;
        if (drain_cnt == DRAIN_LAST) state_nxt = DONE;
      end
      DONE: begin
      end
      default: state_nxt = IDLE;
    endcase

    // Nothing moves while reset is asserted.
    if (i_reset) begin
      adv          = 1'b0;
      pc_we        = 1'b0;
      if_id_we     = 1'b0;
      if_id_flush  = 1'b0;
      id_ex_bubble = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state     <= IDLE;
      drain_cnt <= '0;
      cycle_cnt <= '0;
    end else begin
      state     <= state_nxt;
      drain_cnt <= drain_nxt;
      if (state == IDLE && i_start) cycle_cnt <= '0;
      else if (adv)                 cycle_cnt <= sat_inc(cycle_cnt);
    end
  end

  assign o_adv          = adv;
  assign o_pc_we        = pc_we;
  assign o_if_id_we     = if_id_we;
  assign o_if_id_flush  = if_id_flush;
  assign o_id_ex_bubble = id_ex_bubble;
  assign o_busy         = (state == RUN) || (state == STEP_WAIT) || (state == DRAIN);
  assign o_done         = (state == DONE);
  assign o_state        = state;
  assign o_cycle_cnt    = cycle_cnt;

endmodule

// File: tb/tb_pipeline_sequencer.sv
// tb_pipeline_sequencer
//   Directed scenarios followed by randomized traffic; every cycle the DUT
//   outputs are compared against a behavioural model of the run-control rules.
module tb_pipeline_sequencer;
  localparam int NR = 5;
  localparam int NC = 32;
  localparam int DC = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, start, step_mode, step, halt_id, jump_taken;
  logic [NR-1:0] id_rs, id_rt, ex_rt;
  logic          id_uses_rt, ex_mem_read;
  logic          adv, pc_we, if_id_we, if_id_flush, id_ex_bubble, busy, done;
  logic [2:0]    state;
  logic [NC-1:0] cycle_cnt;

  pipeline_sequencer #(.N_BITS_REG(NR), .N_BITS_CNT(NC), .DRAIN_CYCLES(DC)) dut (
    .i_clk(clk), .i_reset(rst), .i_start(start), .i_step_mode(step_mode),
    .i_step(step), .i_halt_id(halt_id), .i_jump_taken(jump_taken),
    .i_id_rs(id_rs), .i_id_rt(id_rt), .i_id_uses_rt(id_uses_rt),
    .i_ex_mem_read(ex_mem_read), .i_ex_rt(ex_rt),
    .o_adv(adv), .o_pc_we(pc_we), .o_if_id_we(if_id_we),
    .o_if_id_flush(if_id_flush), .o_id_ex_bubble(id_ex_bubble),
    .o_busy(busy), .o_done(done), .o_state(state), .o_cycle_cnt(cycle_cnt)
  );

  int checks = 0;
  int errors = 0;

  // Model: mode is 0..4 as named in the interface; drain_left counts the
  // drain cycles still owed after HALT left ID.
  int            m_mode = 0;
  int            m_drain_left = 0;
  longint        m_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic load_use();
    if (!ex_mem_read || ex_rt == 0) return 1'b0;
    if (ex_rt == id_rs) return 1'b1;
    return id_uses_rt && (ex_rt == id_rt);
  endfunction

  // One clock: check outputs for the applied inputs, then step the model.
  task automatic cycle();
    logic e_adv, e_pc, e_ifwe, e_flush, e_bub, hz, moving;
    e_adv = 0; e_pc = 0; e_ifwe = 0; e_flush = 0; e_bub = 0;
    hz = load_use();
    moving = (m_mode == 1) || (m_mode == 2 && step);
    if (m_mode == 1 || m_mode == 2) begin
      if (moving) begin
        e_adv = 1;
        if (hz)            e_bub = 1;
        else if (!halt_id) begin e_pc = 1; e_ifwe = 1; e_flush = jump_taken; end
      end
    end else if (m_mode == 3) begin
      e_adv = 1; e_flush = 1; e_bub = 1;
    end
    if (rst) begin
      e_adv = 0; e_pc = 0; e_ifwe = 0; e_flush = 0; e_bub = 0;
    end
    #2;
    chk("adv", 32'(adv), 32'(e_adv));
    chk("pc_we", 32'(pc_we), 32'(e_pc));
    if (m_mode != 3) chk("if_id_we", 32'(if_id_we), 32'(e_ifwe));
    chk("flush", 32'(if_id_flush), 32'(e_flush));
    chk("bubble", 32'(id_ex_bubble), 32'(e_bub));
    chk("busy", 32'(busy), 32'(m_mode >= 1 && m_mode <= 3));
    chk("done", 32'(done), 32'(m_mode == 4));
    chk("state", 32'(state), 32'(m_mode));
    chk("cycle_cnt", cycle_cnt, 32'(m_cnt));
    @(posedge clk);
    if (rst) begin
      m_mode = 0; m_cnt = 0; m_drain_left = 0;
    end else begin
      if (e_adv && m_cnt < 64'hFFFF_FFFF) m_cnt++;
      case (m_mode)
        0: if (start) begin m_cnt = 0; m_mode = step_mode ? 2 : 1; end
        1, 2: if (moving && !hz && halt_id) begin m_mode = 3; m_drain_left = DC; end
        3: begin
          m_drain_left--;
          if (m_drain_left == 0) m_mode = 4;
        end
        default: ;
      endcase
    end
    #1;
  endtask

  task automatic clr();
    rst = 0; start = 0; step_mode = 0; step = 0; halt_id = 0; jump_taken = 0;
    id_rs = 0; id_rt = 0; id_uses_rt = 0; ex_mem_read = 0; ex_rt = 0;
  endtask

  task automatic do_reset();
    clr(); rst = 1; cycle(); rst = 0;
  endtask

  initial begin
    clr();
    rst = 1;
    @(posedge clk); #1;

    // Reset then idle
    cycle();
    rst = 0;
    repeat (10) cycle();
    chk("idle_state", 32'(state), 0);
    chk("idle_cnt", cycle_cnt, 0);

    // Continuous run, HALT in cycle 5
    start = 1; cycle();
    start = 0; repeat (4) cycle();
    halt_id = 1; #1;
    chk("halt_pc_we", 32'(pc_we), 0);
    chk("halt_adv", 32'(adv), 1);
    cycle();
    halt_id = 0;
    chk("drain_state", 32'(state), 3);
    repeat (3) cycle();
    chk("done_state", 32'(state), 4);
    chk("done_cnt", cycle_cnt, 8);
    start = 1; repeat (3) cycle(); start = 0;
    chk("done_hold_state", 32'(state), 4);
    chk("done_hold_cnt", cycle_cnt, 8);

    // Load-use and jump priority
    do_reset();
    start = 1; cycle(); start = 0;
    ex_mem_read = 1; ex_rt = 3; id_rs = 3; #1;
    chk("lu_pc_we", 32'(pc_we), 0);
    chk("lu_bubble", 32'(id_ex_bubble), 1);
    cycle();
    ex_rt = 0; id_rs = 0; #1;
    chk("lu_r0_pc_we", 32'(pc_we), 1);
    cycle();
    ex_rt = 3; id_rs = 1; id_rt = 3; id_uses_rt = 0; #1;
    chk("lu_nort_pc_we", 32'(pc_we), 1);
    cycle();
    id_uses_rt = 1; #1;
    chk("lu_rt_bubble", 32'(id_ex_bubble), 1);
    cycle();
    ex_mem_read = 0; jump_taken = 1; #1;
    chk("jmp_flush", 32'(if_id_flush), 1);
    chk("jmp_pc_we", 32'(pc_we), 1);
    cycle();
    ex_mem_read = 1; #1;
    chk("jmp_hz_flush", 32'(if_id_flush), 0);
    chk("jmp_hz_bubble", 32'(id_ex_bubble), 1);
    cycle();
    ex_mem_read = 0; halt_id = 1; #1;
    chk("halt_jmp_flush", 32'(if_id_flush), 0);
    cycle();
    clr();
    chk("halt_jmp_drain", 32'(state), 3);
    repeat (4) cycle();

    // Single-step mode
    do_reset();
    step_mode = 1; start = 1; cycle();
    start = 0; step_mode = 0;
    repeat (5) cycle();
    chk("step_idle_cnt", cycle_cnt, 0);
    chk("step_state", 32'(state), 2);
    repeat (3) begin
      step = 1; cycle();
      step = 0; cycle();
    end
    chk("step_cnt", cycle_cnt, 3);
    step = 1; halt_id = 1; cycle();
    step = 0; halt_id = 0;
    repeat (3) cycle();
    chk("step_done", 32'(state), 4);
    chk("step_done_cnt", cycle_cnt, 7);

    // Reset in the second drain cycle
    do_reset();
    start = 1; cycle(); start = 0;
    cycle();
    halt_id = 1; cycle(); halt_id = 0;
    cycle();
    rst = 1; cycle(); rst = 0;
    chk("mid_drain_state", 32'(state), 0);
    chk("mid_drain_cnt", cycle_cnt, 0);
    start = 1; cycle(); start = 0;
    repeat (3) cycle();
    chk("restart_state", 32'(state), 1);
    chk("restart_cnt", cycle_cnt, 3);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rst         = ($urandom_range(0, 79) == 0);
      start       = ($urandom_range(0, 5) == 0);
      step_mode   = 1'($urandom);
      step        = 1'($urandom);
      halt_id     = ($urandom_range(0, 11) == 0);
      jump_taken  = ($urandom_range(0, 3) == 0);
      ex_mem_read = 1'($urandom);
      id_uses_rt  = 1'($urandom);
      id_rs       = 5'($urandom_range(0, 3));
      id_rt       = 5'($urandom_range(0, 3));
      ex_rt       = 5'($urandom_range(0, 3));
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_sequencer.md
# pipeline_sequencer

Run-control and hazard controller for the 5-stage MIPS pipeline. It sits beside the decode-stage control unit. It decides each cycle whether the pipeline advances, stalls on a load-use hazard, flushes IF/ID on a taken jump or branch, or drains after a HALT instruction. It supports free-running and single-step execution, so a debug host can start the core, clock it one instruction at a time, and detect completion.

## Interface
- N_BITS_REG, 5, register-index width
- N_BITS_CNT, 32, cycle-counter width
- DRAIN_CYCLES, 3, advance cycles after HALT leaves ID until HALT has left WB
- i_clk  in  1  clock, all state updates on rising edge
- i_reset  in  1  synchronous, active-high; returns block to IDLE
- i_start  in  1  pulse; leaves IDLE
- i_step_mode  in  1  sampled only on the i_start cycle; 1 = single-step, 0 = continuous
- i_step  in  1  pulse; one advance in STEP_WAIT
- i_halt_id  in  1  instruction in ID is HALT
- i_jump_taken  in  1  jump/taken branch resolved in ID this cycle
- i_id_rs  in  N_BITS_REG  rs of instruction in ID
- i_id_rt  in  N_BITS_REG  rt of instruction in ID
- i_id_uses_rt  in  1  ID instruction reads rt as a source
- i_ex_mem_read  in  1  instruction in EX is a load
- i_ex_rt  in  N_BITS_REG  destination of load in EX
- o_adv  out  1  pipeline registers ID/EX, EX/MEM, MEM/WB enabled
- o_pc_we  out  1  PC write enable
- o_if_id_we  out  1  IF/ID write enable
- o_if_id_flush  out  1  load NOP into IF/ID
- o_id_ex_bubble  out  1  zero control signals into ID/EX
- o_busy  out  1  state is RUN, STEP_WAIT or DRAIN
- o_done  out  1  state is DONE
- o_state  out  3  IDLE=0, RUN=1, STEP_WAIT=2, DRAIN=3, DONE=4
- o_cycle_cnt  out  N_BITS_CNT  number of cycles with o_adv=1 since start

## Operation
- The FSM is registered. All enable outputs are combinational from the current state and the current inputs (Mealy).
- **IDLE:** all enables are 0. On i_start, go to STEP_WAIT if i_step_mode=1, else go to RUN, and clear o_cycle_cnt.
- **RUN:** adv=1 every cycle.
- **STEP_WAIT:** adv=i_step.
- **DRAIN:** adv=1 every cycle, independent of the step mode.
- **DONE:** all enables are 0 and o_done=1. DONE is left only by i_reset; i_start is ignored.
- **Hazard:** hz = i_ex_mem_read && i_ex_rt != 0 && (i_ex_rt == i_id_rs || (i_id_uses_rt && i_ex_rt == i_id_rt)).
- **Priority when adv=1 in RUN or STEP_WAIT** (highest first):
  - hz: pc_we=0, if_id_we=0, id_ex_bubble=1. Halt and jump are ignored this cycle.
  - i_halt_id: pc_we=0, if_id_we=0, if_id_flush=0, id_ex_bubble=0 (HALT enters EX). Next state is DRAIN and the drain counter loads 0.
  - i_jump_taken: pc_we=1, if_id_we=1, if_id_flush=1.
  - Otherwise: pc_we=1, if_id_we=1, and the other control outputs are 0.
- **Any state with adv=0:** pc_we, if_id_we, if_id_flush and id_ex_bubble are all 0.
- **DRAIN:**
  - pc_we=0 and if_id_flush=1.
  - id_ex_bubble=1, so a stale ID instruction never follows HALT.
  - Hazard logic is ignored.
  - The drain counter increments on each cycle. When it equals DRAIN_CYCLES-1, the next state is DONE.
- **o_cycle_cnt:** increments on every cycle with o_adv=1, including stall and drain cycles. It saturates at all-ones.
- **Reset:** i_reset in any state, including mid-DRAIN, gives state IDLE, o_cycle_cnt=0, drain counter 0 and step mode 0 on the next edge. The enable outputs are 0 during the reset cycle.

## Timing
- **Reset values:** o_state=0, o_busy=0, o_done=0, o_cycle_cnt=0, and all enables 0.
- i_start at edge k gives o_state=RUN (or STEP_WAIT) after edge k. The first adv=1 is in cycle k+1.
- **Stall:** one cycle per load-use hazard. The bubble enters ID/EX at the same edge where PC and IF/ID hold.
- **HALT:** from the cycle HALT is in ID to o_done=1 is 1 + DRAIN_CYCLES cycles. In continuous mode the default is o_done asserted 4 cycles after the i_halt_id cycle.
- **Step mode:** each i_step pulse gives exactly one advance. i_step held high for N cycles gives N advances. i_step outside STEP_WAIT is ignored.
- i_step_mode changes after the i_start cycle have no effect.

## Test plan
- **Reset then idle:** i_reset=1 for 2 cycles, then 10 idle cycles -> all outputs 0, o_state=0, o_cycle_cnt=0.
- **Continuous run and halt:** i_start with i_step_mode=0, then i_halt_id=1 in cycle 5 -> pc_we=0 from cycle 5, DRAIN in cycles 6-8, o_done=1 from cycle 9, o_cycle_cnt=8 and frozen.
- **Load-use:** i_ex_mem_read=1, i_ex_rt=3, i_id_rs=3 -> pc_we=0, if_id_we=0, id_ex_bubble=1 for that cycle. Repeat with i_ex_rt=0 -> no stall. Repeat with rt match and i_id_uses_rt=0 -> no stall.
- **Jump flush and priority:**
  - i_jump_taken=1 alone -> if_id_flush=1, pc_we=1.
  - i_jump_taken=1 together with a hazard -> stall only, no flush.
  - i_halt_id=1 and i_jump_taken=1 together -> DRAIN, no flush that cycle.
- **Step mode:** i_start with i_step_mode=1, then 5 idle cycles -> o_cycle_cnt=0. Three single-cycle i_step pulses -> o_cycle_cnt=3. HALT on a step -> DRAIN completes in 3 cycles without further i_step.
- **Reset mid-drain:** i_reset in the second DRAIN cycle -> o_state=0 and o_cycle_cnt=0 next cycle. A following i_start runs normally.
